detector_session_arbiter: RTL and testbench

Session arbiter that shares one sequence-detector datapath (2-bit symbol in, CNT_W-bit recognised-sequence counter out) between N_REQ requesters.
- Grants the detector to one requester per session and clears it at session start.
- Steers the owner's symbols into the detector.
- Captures the final count into a result register at session end and pulses `done` to the owner.
- Sits between the requester front-ends and the detector's data_path/control_unit pair.

---
 rtl/detarb_pkg.sv | 21 ++
 rtl/detector_session_arbiter_rr_picker.sv | 49 ++++
 rtl/detector_session_arbiter.sv | 119 +++++++++++
 tb/tb_detector_session_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/detarb_pkg.sv
// Shared types and constants for the detector session arbiter slice.
// Feature macro DETARB_FIXED_PRIO_EN (see rr_picker / top) switches to fixed priority.
package detarb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_REPORT
  } state_t;

  localparam int unsigned CNT_W_DEF = 4;
  localparam int unsigned N_REQ_DEF = 4;

  localparam logic [1:0] SYM_00 = 2'b00;
  localparam logic [1:0] SYM_01 = 2'b01;
  localparam logic [1:0] SYM_10 = 2'b10;
  localparam logic [1:0] SYM_11 = 2'b11;

endpackage

// File: rtl/detector_session_arbiter_rr_picker.sv
// Combinational requester picker: round-robin from ptr, or lowest index when
// DETARB_FIXED_PRIO_EN is defined.
module rr_picker
  import detarb_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] pick,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

`ifdef DETARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && req[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
    pick = found ? (N_REQ'(1) << idx) : '0;
  end
`else
  logic [IDX_W-1:0] cand;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = IDX_W'((k + 32'(ptr)) % N_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    pick = found ? (N_REQ'(1) << idx) : '0;
  end
`endif

endmodule

// File: rtl/detector_session_arbiter.sv
// Grants a shared sequence detector to one requester per session, steers its
// symbols, and reports the final count. DETARB_FIXED_PRIO_EN selects fixed priority.
module detector_session_arbiter
  import detarb_pkg::*;
#(
  parameter int unsigned N_REQ    = N_REQ_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [2*N_REQ-1:0] sym,
  input  logic [N_REQ-1:0]   sym_valid,
  output logic [N_REQ-1:0]   gnt,
  output logic               det_clr,
  output logic               det_en,
  output logic [1:0]         det_x,
  input  logic [CNT_W-1:0]   det_count,
  output logic [N_REQ-1:0]   done,
  output logic [CNT_W-1:0]   result,
  output logic               busy
);

  localparam int unsigned IDX_W  = $clog2(N_REQ);
  localparam int unsigned HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);

  state_t            state;
  logic [IDX_W-1:0]  owner;
  logic [IDX_W-1:0]  ptr;
  logic [HOLD_W-1:0] hold;

  logic [N_REQ-1:0]  pick;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;
  logic [N_REQ-1:0]  owner_oh;
  logic [N_REQ-1:0]  rivals;
  logic              owner_req;
  logic              preempt;

  rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req   (req),
    .ptr   (ptr),
    .pick  (pick),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign owner_oh  = N_REQ'(1) << owner;
  assign owner_req = req[owner];

`ifdef DETARB_FIXED_PRIO_EN
  assign rivals = req & (owner_oh - N_REQ'(1));
`else
  assign rivals = req & ~owner_oh;
`endif

  assign preempt = (MAX_HOLD != 0) && (hold == HOLD_LIMIT) && (|rivals);

  // Owner dropping req also masks its strobe, so a drop during CLEAR yields an empty RUN cycle.
  assign det_en = (state == S_RUN) && owner_req && sym_valid[owner];
  assign det_x  = det_en ? sym[{owner, 1'b0} +: 2] : SYM_00;
  assign busy   = (state != S_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      owner   <= '0;
      ptr     <= '0;
      hold    <= '0;
      gnt     <= '0;
      det_clr <= 1'b0;
      done    <= '0;
      result  <= '0;
    end else begin
      det_clr <= 1'b0;
      done    <= '0;
      unique case (state)
        S_IDLE: begin
          if (pick_found) begin
            owner   <= pick_idx;
            gnt     <= pick;
            det_clr <= 1'b1;
            hold    <= '0;
            state   <= S_CLEAR;
          end
        end
        S_CLEAR: state <= S_RUN;
        S_RUN: begin
          if (!owner_req || preempt) begin
            state <= S_DRAIN;
          end else if (hold == HOLD_LIMIT) begin
            hold <= '0;
          end else begin
            hold <= hold + 1'b1;
          end
        end
        // Capture on entry to REPORT so result is already valid while done pulses.
        S_DRAIN: begin
          result <= det_count;
          done   <= owner_oh;
          state  <= S_REPORT;
        end
        S_REPORT: begin
          gnt   <= '0;
          hold  <= '0;
          ptr   <= (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_detector_session_arbiter.sv
// Directed/randomized bench for detector_session_arbiter with an in-bench
// pair-counting detector (01 followed by 10) and a session-level reference model.
module tb_detector_session_arbiter;

  localparam int N_REQ    = 4;
  localparam int CNT_W    = 4;
  localparam int MAX_HOLD = 16;

  typedef logic [1:0] symq_t[$];

  logic             clock;
  logic             reset;
  logic [3:0]       req_r;
  logic [7:0]       sym_r;
  logic [3:0]       sym_valid_r;
  logic [3:0]       gnt;
  logic             det_clr;
  logic             det_en;
  logic [1:0]       det_x;
  logic [CNT_W-1:0] det_count_m;
  logic [1:0]       prev_m;
  logic [3:0]       done;
  logic [CNT_W-1:0] result;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;
  int ptr_m   = 0;
  int max_gaps = 2;
  logic [1:0] fixed_syms [6];

  detector_session_arbiter #(
    .N_REQ    (N_REQ),
    .CNT_W    (CNT_W),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req_r),
    .sym       (sym_r),
    .sym_valid (sym_valid_r),
    .gnt       (gnt),
    .det_clr   (det_clr),
    .det_en    (det_en),
    .det_x     (det_x),
    .det_count (det_count_m),
    .done      (done),
    .result    (result),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Stand-in detector: counts occurrences of symbol 01 immediately followed by 10.
  always @(posedge clock) begin
    if (reset || det_clr) begin
      det_count_m <= '0;
      prev_m      <= 2'b00;
    end else if (det_en) begin
      if (prev_m == 2'b01 && det_x == 2'b10) det_count_m <= det_count_m + 1'b1;
      prev_m <= det_x;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int pick_model(input logic [3:0] r, input int p);
`ifdef DETARB_FIXED_PRIO_EN
    for (int i = 0; i < N_REQ; i++) if (r[i]) return i;
`else
    for (int k = 0; k < N_REQ; k++) if (r[(p + k) % N_REQ]) return (p + k) % N_REQ;
`endif
    return -1;
  endfunction

  function automatic int count_model(input symq_t q);
    int n = 0;
    for (int i = 0; i + 1 < q.size(); i++)
      if (q[i] == 2'b01 && q[i+1] == 2'b10) n++;
    return n % (1 << CNT_W);
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    req_r = '0;
    sym_valid_r = '0;
    tick();
    tick();
    reset = 1'b0;
    ptr_m = 0;
  endtask

  // One full session starting with the DUT in IDLE and req_r already driven.
  task automatic run_session(input int nsym, input int mode, input int raise_idx,
                             input int raise_at, input bit reraise);
    int g, c, acc, gaps, en_seen, exp_cnt;
    logic [3:0] oh;
    logic [1:0] s;
    logic e;
    bit last, others;
    symq_t q;
    g = pick_model(req_r, ptr_m);
    if (g < 0) begin
      check("no_requester", 0, 1);
      return;
    end
    oh = 4'(1 << g);
    tick();
    sym_r = 8'($urandom);
    sym_valid_r = '1;
    if (nsym == 0) req_r[g] = 1'b0;
    #1;
    check("clear_gnt", gnt, oh);
    check("clear_pulse", det_clr, 1);
    check("clear_en", det_en, 0);
    check("clear_busy", busy, 1);
    check("clear_done", done, 0);
    tick();
    acc = 0; gaps = 0; c = 0; en_seen = 0; last = 0;
    while (!last) begin
      if (raise_idx >= 0 && c == raise_at) req_r[raise_idx] = 1'b1;
      sym_r = 8'($urandom);
      sym_valid_r = 4'($urandom);
      if (acc == nsym) begin
        req_r[g] = 1'b0;
        sym_valid_r[g] = 1'b1;
        last = 1;
      end else begin
        sym_valid_r[g] = (gaps >= max_gaps) || ($urandom_range(0, 3) != 0);
        if (!sym_valid_r[g]) gaps++;
        if (mode == 1) s = (acc % 2 == 0) ? 2'b01 : 2'b10;
        else if (mode == 2) s = fixed_syms[acc];
        else s = 2'($urandom);
        sym_r[2*g +: 2] = s;
        if (sym_valid_r[g]) begin
          q.push_back(s);
          acc++;
        end
`ifdef DETARB_FIXED_PRIO_EN
        others = |(req_r & (oh - 4'd1));
`else
        others = |(req_r & ~oh);
`endif
        if ((c % (MAX_HOLD + 1)) == MAX_HOLD && others) last = 1;
      end
      e = req_r[g] & sym_valid_r[g];
      #1;
      check("run_gnt", gnt, oh);
      check("run_clr", det_clr, 0);
      check("run_done", done, 0);
      check("run_en", det_en, e);
      check("run_x", det_x, e ? sym_r[2*g +: 2] : 2'b00);
      if (det_en) en_seen++;
      tick();
      c++;
      if (c > 1000) begin
        check("run_timeout", 0, 1);
        last = 1;
      end
    end
    sym_valid_r = '1;
    #1;
    check("drain_en", det_en, 0);
    check("drain_gnt", gnt, oh);
    check("drain_done", done, 0);
    check("drain_busy", busy, 1);
    check("en_count", en_seen, acc);
    tick();
    exp_cnt = count_model(q);
    check("report_done", done, oh);
    check("report_result", result, exp_cnt);
    check("report_busy", busy, 1);
    if (reraise) req_r[g] = 1'b1;
    tick();
    ptr_m = (g + 1) % N_REQ;
    check("idle_done", done, 0);
    check("idle_gnt", gnt, 0);
    check("idle_busy", busy, 0);
    check("idle_result", result, exp_cnt);
  endtask

  initial begin
    fixed_syms = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10};
    sym_r = '0;
    do_reset();

    // Idle after reset: nothing moves even with stray strobes.
    check("rst_gnt", gnt, 0);
    check("rst_result", result, 0);
    for (int i = 0; i < 20; i++) begin
      sym_r = 8'($urandom);
      sym_valid_r = 4'($urandom);
      tick();
      check("idle_gnt0", gnt, 0);
      check("idle_busy0", busy, 0);
      check("idle_done0", done, 0);
      check("idle_clr0", det_clr, 0);
      check("idle_en0", det_en, 0);
      check("idle_x0", det_x, 0);
    end

    // Fixed symbol list on requester 1.
    req_r = 4'b0010;
    run_session(6, 2, -1, 0, 0);

    // Reset during RUN aborts the session silently.
    req_r = 4'b0010;
    tick();
    tick();
    sym_valid_r = '1;
    tick();
    reset = 1'b1;
    req_r = '0;
    tick();
    check("abort_gnt", gnt, 0);
    check("abort_done", done, 0);
    check("abort_busy", busy, 0);
    check("abort_result", result, 0);
    reset = 1'b0;
    ptr_m = 0;
    tick();
    check("abort_done2", done, 0);

    // Two simultaneous requesters from reset.
    do_reset();
    req_r = 4'b0101;
    run_session($urandom_range(3, 8), 0, -1, 0, 0);
    run_session($urandom_range(3, 8), 0, -1, 0, 0);

    // Preemption of a long session, then an uncontested long session.
    do_reset();
    max_gaps = 0;
    req_r = 4'b1000;
    run_session(100, 0, 0, 5, 0);
    run_session(4, 0, -1, 0, 0);
    run_session(40, 0, -1, 0, 0);

    // 17 recognised pairs wrap the counter.
    req_r = 4'b0001;
    run_session(34, 1, -1, 0, 0);
    max_gaps = 2;

    // Owner drops req during CLEAR.
    req_r = 4'b0100;
    run_session(0, 0, -1, 0, 0);

    // Contention between requesters 1 and 2.
    req_r = 4'b0110;
    for (int i = 0; i < 4; i++) run_session($urandom_range(2, 6), 0, -1, 0, 1);
    req_r = '0;

    // Random request sets.
    tick();
    for (int i = 0; i < 8; i++) begin
      req_r = 4'($urandom_range(1, 15));
      run_session($urandom_range(0, 6), 0, -1, 0, 1);
    end
    req_r = '0;
    tick();
    tick();
    check("final_busy", busy, 0);
    check("final_gnt", gnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
